// File: rtl/host_cmd_seq.sv
// host_cmd_seq: hardware command sequencer for the host side of the comm link.
// Runs a CMD_ACK write, a spaced/limited status POLL, or a fixed-length DUMP
// through the comm master handshake (host_cmd/send_cmd/cmd_sent,
// resp/resp_rdy/clr_resp_rdy) and reports completion via done/err_code.
// Control: start, op, cmd, poll_mask in; busy, done, err_code, last_resp out.
// Dump stream: dump_data, dump_vld, dump_cnt out.
module host_cmd_seq #(
  parameter int unsigned DUMP_DEPTH   = 384,
  parameter int unsigned POLL_GAP     = 800,
  parameter int unsigned POLL_MAX     = 200,
  parameter int unsigned RESP_TIMEOUT = 6000,
  parameter logic [7:0]  ACK          = 8'hA5,
  localparam int unsigned DCW = $clog2(DUMP_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           RST_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [15:0]    cmd,
  input  logic [7:0]     poll_mask,
  output logic           busy,
  output logic           done,
  output logic [1:0]     err_code,
  output logic [7:0]     last_resp,
  output logic [7:0]     dump_data,
  output logic           dump_vld,
  output logic [DCW-1:0] dump_cnt,
  output logic [15:0]    host_cmd,
  output logic           send_cmd,
  input  logic           cmd_sent,
  input  logic [7:0]     resp,
  input  logic           resp_rdy,
  output logic           clr_resp_rdy
);

  localparam int unsigned GW = (POLL_GAP > 1)     ? $clog2(POLL_GAP)     : 1;
  localparam int unsigned TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int unsigned PW = (POLL_MAX > 1)     ? $clog2(POLL_MAX)     : 1;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    ACCEPT
  } state_t;

  typedef enum logic [1:0] {
    OP_CMD_ACK = 2'b00,
    OP_POLL    = 2'b01,
    OP_DUMP    = 2'b10,
    OP_RSVD    = 2'b11
  } op_t;

  state_t        state;
  op_t           op_l;
  logic [15:0]   cmd_l;
  logic [7:0]    mask_l;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] timer;
  logic [PW-1:0] poll_cnt;
  logic          sent_q;
  logic          sent_rise;
  logic          rdy_q;
  logic          rdy_rise;
  logic [7:0]    resp_q;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state        <= IDLE;
      op_l         <= OP_CMD_ACK;
      cmd_l        <= '0;
      mask_l       <= '0;
      gap_cnt      <= '0;
      timer        <= '0;
      poll_cnt     <= '0;
      sent_q       <= 1'b0;
      sent_rise    <= 1'b0;
      rdy_q        <= 1'b0;
      rdy_rise     <= 1'b0;
      resp_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_code     <= '0;
      last_resp    <= '0;
      dump_data    <= '0;
      dump_vld     <= 1'b0;
      dump_cnt     <= '0;
      host_cmd     <= '0;
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
    end else begin
      // Edges are registered here and acted on one cycle later, so a
      // response edge at cycle n yields ACCEPT outputs at n+2.
      sent_q    <= cmd_sent;
      sent_rise <= cmd_sent & ~sent_q;
      rdy_q     <= resp_rdy;
      rdy_rise  <= resp_rdy & ~rdy_q;
      resp_q    <= resp;

      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      dump_vld     <= 1'b0;
      done         <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            op_l     <= op_t'(op);
            cmd_l    <= cmd;
            mask_l   <= poll_mask;
            busy     <= 1'b1;
            dump_cnt <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            case (op_t'(op))
              OP_RSVD: state <= ACCEPT;
              OP_POLL: state <= GAP;
              default: state <= SEND;
            endcase
          end
        end

        GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        SEND: begin
          host_cmd <= cmd_l;
          send_cmd <= 1'b1;
          state    <= WAIT_SENT;
        end

        WAIT_SENT: begin
          if (sent_rise) begin
            timer <= '0;
            state <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          // A response landing on the final timeout cycle still wins.
          if (rdy_rise) begin
            last_resp <= resp_q;
            state     <= ACCEPT;
          end else if (timer == TW'(RESP_TIMEOUT - 1)) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            err_code <= 2'b10;
            state    <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ACCEPT: begin
          case (op_l)
            OP_RSVD: begin
              done     <= 1'b1;
              busy     <= 1'b0;
              err_code <= 2'b01;
              state    <= IDLE;
            end
            OP_CMD_ACK: begin
              clr_resp_rdy <= 1'b1;
              done         <= 1'b1;
              busy         <= 1'b0;
              err_code     <= (last_resp == ACK) ? 2'b00 : 2'b01;
              state        <= IDLE;
            end
            OP_POLL: begin
              clr_resp_rdy <= 1'b1;
              if ((last_resp & mask_l) != 8'h00) begin
                done     <= 1'b1;
                busy     <= 1'b0;
                err_code <= 2'b00;
                state    <= IDLE;
              end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                done     <= 1'b1;
                busy     <= 1'b0;
                err_code <= 2'b11;
                state    <= IDLE;
              end else begin
                poll_cnt <= poll_cnt + PW'(1);
                gap_cnt  <= '0;
                state    <= GAP;
              end
            end
            default: begin
              clr_resp_rdy <= 1'b1;
              dump_vld     <= 1'b1;
              dump_data    <= last_resp;
              dump_cnt     <= dump_cnt + DCW'(1);
              if (dump_cnt == DCW'(DUMP_DEPTH - 1)) begin
                done     <= 1'b1;
                busy     <= 1'b0;
                err_code <= 2'b00;
                state    <= IDLE;
              end else begin
                timer <= '0;
                state <= WAIT_RESP;
              end
            end
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_seq.sv
module tb_host_cmd_seq;

  localparam int DEPTH = 384;
  localparam int GAPC  = 50;
  localparam int PMAX  = 4;
  localparam int TMO   = 300;
  localparam logic [7:0] ACKB = 8'hA5;
  localparam int DCW = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           RST_n = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [15:0]    cmd = 16'h0000;
  logic [7:0]     poll_mask = 8'h00;
  logic           busy;
  logic           done;
  logic [1:0]     err_code;
  logic [7:0]     last_resp;
  logic [7:0]     dump_data;
  logic           dump_vld;
  logic [DCW-1:0] dump_cnt;
  logic [15:0]    host_cmd;
  logic           send_cmd;
  logic           cmd_sent;
  logic [7:0]     resp;
  logic           resp_rdy;
  logic           clr_resp_rdy;

  host_cmd_seq #(
    .DUMP_DEPTH  (DEPTH),
    .POLL_GAP    (GAPC),
    .POLL_MAX    (PMAX),
    .RESP_TIMEOUT(TMO),
    .ACK         (ACKB)
  ) dut (
    .clk         (clk),
    .RST_n       (RST_n),
    .start       (start),
    .op          (op),
    .cmd         (cmd),
    .poll_mask   (poll_mask),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code),
    .last_resp   (last_resp),
    .dump_data   (dump_data),
    .dump_vld    (dump_vld),
    .dump_cnt    (dump_cnt),
    .host_cmd    (host_cmd),
    .send_cmd    (send_cmd),
    .cmd_sent    (cmd_sent),
    .resp        (resp),
    .resp_rdy    (resp_rdy),
    .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Monitor (sole writer of these), samples 1 time unit after each edge.
  int         n_send = 0;
  int         n_clr  = 0;
  int         n_vld  = 0;
  int         n_done = 0;
  int         send_cycs[$];
  int         clr_cycs[$];
  logic [7:0] dump_log[$];
  logic [1:0] done_err = 2'b00;
  int         done_cyc = 0;
  logic       done_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    if (send_cmd === 1'b1) begin
      n_send++;
      send_cycs.push_back(cyc);
    end
    if (clr_resp_rdy === 1'b1) begin
      n_clr++;
      clr_cycs.push_back(cyc);
    end
    if (dump_vld === 1'b1) begin
      n_vld++;
      dump_log.push_back(dump_data);
    end
    if (done === 1'b1) begin
      n_done++;
      done_err  = err_code;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  // Test-owned stimulus state for the comm master model.
  logic [7:0] rep[$];
  int         per_send  = 0;
  logic       master_en = 1'b0;
  int         op_id     = 0;
  int         start_cyc = 0;
  int         b_send = 0, b_clr = 0, b_vld = 0, b_done = 0;

  // Comm master model (sole writer of these).
  int   last_rdy_cyc = 0;
  logic master_busy  = 1'b0;

  initial begin : master
    int idx;
    int seen;
    int w;
    idx = 0;
    seen = 0;
    cmd_sent = 1'b0;
    resp_rdy = 1'b0;
    resp = 8'h00;
    forever begin
      @(negedge clk);
      if (seen != op_id) begin
        seen = op_id;
        idx = 0;
      end
      if (send_cmd === 1'b1 && master_en) begin
        master_busy = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        cmd_sent = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        cmd_sent = 1'b0;
        for (int k = 0; k < per_send; k++) begin
          if (idx >= rep.size() || !master_en) break;
          repeat ($urandom_range(1, 3)) @(negedge clk);
          resp = rep[idx];
          idx++;
          resp_rdy = 1'b1;
          last_rdy_cyc = cyc + 1;
          w = 0;
          while (clr_resp_rdy !== 1'b1 && master_en && w < TMO + 50) begin
            @(negedge clk);
            w++;
          end
          resp_rdy = 1'b0;
        end
        master_busy = 1'b0;
      end
    end
  end

  task automatic snap();
    b_send = n_send;
    b_clr  = n_clr;
    b_vld  = n_vld;
    b_done = n_done;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] c, input logic [7:0] m,
                        input int ps, input int budget, output logic ended);
    int k;
    @(negedge clk);
    snap();
    per_send  = ps;
    master_en = 1'b1;
    op_id++;
    op        = o;
    cmd       = c;
    poll_mask = m;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
    op        = 2'b00;
    cmd       = 16'h0000;
    poll_mask = 8'h00;
    k = 0;
    while (n_done == b_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    ended = (n_done != b_done);
    k = 0;
    while (master_busy && k < 2 * TMO) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    RST_n = 1'b1;
    #2;
    RST_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, err_code, last_resp, dump_data, dump_vld, dump_cnt, host_cmd,
         send_cmd, clr_resp_rdy} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b err=%b last=%h ddata=%h vld=%b cnt=%0d hcmd=%h send=%b clr=%b, want all 0",
               busy, done, err_code, last_resp, dump_data, dump_vld, dump_cnt, host_cmd, send_cmd, clr_resp_rdy);
    if ({busy, done, err_code, last_resp, dump_data, dump_vld, dump_cnt, host_cmd,
         send_cmd, clr_resp_rdy} !== '0) fails++;
    RST_n = 1'b1;
    snap();
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || n_send != b_send) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b sends=%0d, want busy=0 sends=0", busy, n_send - b_send);
    end
  endtask

  task automatic test_cmd_ack();
    for (int t = 0; t < 10; t++) begin
      logic [15:0] c;
      logic [7:0]  b;
      logic        ended;
      logic [1:0]  exp_err;
      int          scyc;
      if (t == 0) begin
        c = 16'h4110; b = 8'hA5;
      end else if (t == 1) begin
        c = 16'h4110; b = 8'hEE;
      end else begin
        c = 16'($urandom);
        b = ($urandom_range(0, 2) == 0) ? ACKB : 8'($urandom);
      end
      rep.delete();
      rep.push_back(b);
      run_op(2'b00, c, 8'h00, 1, 200, ended);
      exp_err = (b == ACKB) ? 2'b00 : 2'b01;
      tests++;
      if (!ended) begin
        fails++;
        $display("FAIL ack_done[%0d]: got no done, want done", t);
      end
      tests++;
      if (done_err !== exp_err) begin
        fails++;
        $display("FAIL ack_err[%0d]: got %b want %b (byte %h)", t, done_err, exp_err, b);
      end
      tests++;
      if (last_resp !== b) begin
        fails++;
        $display("FAIL ack_last_resp[%0d]: got %h want %h", t, last_resp, b);
      end
      tests++;
      if (n_send - b_send != 1 || host_cmd !== c) begin
        fails++;
        $display("FAIL ack_send[%0d]: sends=%0d host_cmd=%h, want 1 and %h", t, n_send - b_send, host_cmd, c);
      end
      tests++;
      if (n_clr - b_clr != 1) begin
        fails++;
        $display("FAIL ack_clr[%0d]: got %0d want 1", t, n_clr - b_clr);
      end
      tests++;
      if (done_cyc != last_rdy_cyc + 2 || done_busy !== 1'b0) begin
        fails++;
        $display("FAIL ack_done_timing[%0d]: done at %0d busy=%b, want %0d busy=0", t, done_cyc, done_busy, last_rdy_cyc + 2);
      end
      scyc = (send_cycs.size() > b_send) ? send_cycs[b_send] : -1;
      tests++;
      if (scyc != start_cyc + 1) begin
        fails++;
        $display("FAIL ack_send_timing[%0d]: send at %0d want %0d", t, scyc, start_cyc + 1);
      end
    end
  endtask

  task automatic test_reserved_op();
    logic ended;
    rep.delete();
    run_op(2'b11, 16'h1234, 8'h00, 1, 20, ended);
    tests++;
    if (!ended || done_err !== 2'b01) begin
      fails++;
      $display("FAIL rsvd_err: ended=%b err=%b, want ended=1 err=01", ended, done_err);
    end
    tests++;
    if (n_send != b_send || n_clr != b_clr) begin
      fails++;
      $display("FAIL rsvd_no_send: sends=%0d clrs=%0d, want 0 0", n_send - b_send, n_clr - b_clr);
    end
    tests++;
    if (done_cyc != start_cyc + 1 || done_busy !== 1'b0) begin
      fails++;
      $display("FAIL rsvd_timing: done at %0d busy=%b, want %0d busy=0", done_cyc, done_busy, start_cyc + 1);
    end
  endtask

  task automatic test_poll();
    for (int t = 0; t < 6; t++) begin
      logic [7:0] m;
      logic       ended;
      int         hit;
      int         exp_sends;
      logic [1:0] exp_err;
      logic [7:0] exp_last;
      int         scyc;
      int         min_gap;
      int         g;
      rep.delete();
      if (t == 0) begin
        m = 8'h20;
        rep.push_back(8'h00); rep.push_back(8'h00); rep.push_back(8'h20);
      end else if (t == 1) begin
        m = 8'h20;
        for (int i = 0; i < PMAX; i++) rep.push_back(8'h03);
      end else begin
        m = 8'($urandom);
        if (m == 8'h00) m = 8'h01;
        for (int i = 0; i < PMAX; i++)
          rep.push_back(($urandom_range(0, 3) == 0) ? (8'($urandom) | m) : (8'($urandom) & ~m));
      end
      hit = -1;
      for (int i = 0; i < rep.size() && i < PMAX; i++)
        if (hit < 0 && (rep[i] & m) != 8'h00) hit = i;
      exp_sends = (hit < 0) ? PMAX : hit + 1;
      exp_err   = (hit < 0) ? 2'b11 : 2'b00;
      exp_last  = rep[exp_sends - 1];
      run_op(2'b01, 16'h0000 + 16'(t), m, 1, PMAX * (GAPC + 40) + 100, ended);
      tests++;
      if (!ended || done_err !== exp_err) begin
        fails++;
        $display("FAIL poll_err[%0d]: ended=%b err=%b, want ended=1 err=%b", t, ended, done_err, exp_err);
      end
      tests++;
      if (n_send - b_send != exp_sends) begin
        fails++;
        $display("FAIL poll_sends[%0d]: got %0d want %0d", t, n_send - b_send, exp_sends);
      end
      tests++;
      if (last_resp !== exp_last) begin
        fails++;
        $display("FAIL poll_last_resp[%0d]: got %h want %h", t, last_resp, exp_last);
      end
      scyc = (send_cycs.size() > b_send) ? send_cycs[b_send] : -1;
      tests++;
      if (scyc != start_cyc + 1 + GAPC) begin
        fails++;
        $display("FAIL poll_first_send[%0d]: at %0d want %0d", t, scyc, start_cyc + 1 + GAPC);
      end
      min_gap = 1000000;
      for (int i = 1; i < exp_sends; i++) begin
        if (b_send + i < send_cycs.size() && b_clr + i - 1 < clr_cycs.size()) begin
          g = send_cycs[b_send + i] - clr_cycs[b_clr + i - 1];
          if (g < min_gap) min_gap = g;
        end else begin
          min_gap = 0;
        end
      end
      if (exp_sends > 1) begin
        tests++;
        if (min_gap < GAPC + 1) begin
          fails++;
          $display("FAIL poll_gap[%0d]: min spacing %0d want >= %0d", t, min_gap, GAPC + 1);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int k;
    rep.delete();
    rep.push_back(8'h00);
    rep.push_back(8'h40);
    @(negedge clk);
    snap();
    per_send  = 1;
    master_en = 1'b1;
    op_id++;
    op = 2'b01; cmd = 16'h2222; poll_mask = 8'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    op = 2'b11; cmd = 16'hFFFF; poll_mask = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'b00; cmd = 16'h0000;
    k = 0;
    while (n_done == b_done && k < 4 * GAPC + 200) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    tests++;
    if (n_done - b_done != 1 || done_err !== 2'b00) begin
      fails++;
      $display("FAIL busy_start_done: dones=%0d err=%b, want 1 and 00", n_done - b_done, done_err);
    end
    tests++;
    if (n_send - b_send != 2 || host_cmd !== 16'h2222 || last_resp !== 8'h40) begin
      fails++;
      $display("FAIL busy_start_op: sends=%0d host_cmd=%h last=%h, want 2 2222 40", n_send - b_send, host_cmd, last_resp);
    end
  endtask

  task automatic test_dump();
    logic ended;
    int   bad;
    logic [7:0] got_b, want_b;
    rep.delete();
    for (int i = 0; i < DEPTH; i++) rep.push_back(8'(i % 128));
    run_op(2'b10, 16'h8100, 8'h00, 1000, DEPTH * 12 + 200, ended);
    tests++;
    if (!ended || done_err !== 2'b00) begin
      fails++;
      $display("FAIL dump_err: ended=%b err=%b, want ended=1 err=00", ended, done_err);
    end
    tests++;
    if (n_vld - b_vld != DEPTH || n_clr - b_clr != DEPTH) begin
      fails++;
      $display("FAIL dump_counts: vld=%0d clr=%0d, want %0d %0d", n_vld - b_vld, n_clr - b_clr, DEPTH, DEPTH);
    end
    bad = 0; got_b = 8'h00; want_b = 8'h00;
    for (int i = 0; i < DEPTH && b_vld + i < dump_log.size(); i++) begin
      if (dump_log[b_vld + i] !== 8'(i % 128)) begin
        if (bad == 0) begin
          got_b = dump_log[b_vld + i];
          want_b = 8'(i % 128);
        end
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL dump_data: %0d bad bytes, first got %h want %h", bad, got_b, want_b);
    end
    tests++;
    if (dump_cnt !== DCW'(DEPTH)) begin
      fails++;
      $display("FAIL dump_cnt: got %0d want %0d", dump_cnt, DEPTH);
    end
    tests++;
    if (n_send - b_send != 1 || host_cmd !== 16'h8100) begin
      fails++;
      $display("FAIL dump_send: sends=%0d host_cmd=%h, want 1 8100", n_send - b_send, host_cmd);
    end
    tests++;
    if (done_cyc != last_rdy_cyc + 2) begin
      fails++;
      $display("FAIL dump_done_timing: at %0d want %0d", done_cyc, last_rdy_cyc + 2);
    end
  endtask

  task automatic test_dump_timeout();
    logic ended;
    int   bad;
    rep.delete();
    for (int i = 0; i < 10; i++) rep.push_back(8'($urandom));
    run_op(2'b10, 16'h8101, 8'h00, 1000, 10 * 12 + TMO + 100, ended);
    tests++;
    if (!ended || done_err !== 2'b10) begin
      fails++;
      $display("FAIL tmo_err: ended=%b err=%b, want ended=1 err=10", ended, done_err);
    end
    tests++;
    if (dump_cnt !== DCW'(10) || n_vld - b_vld != 10) begin
      fails++;
      $display("FAIL tmo_cnt: dump_cnt=%0d vld=%0d, want 10 10", dump_cnt, n_vld - b_vld);
    end
    bad = 0;
    for (int i = 0; i < 10 && b_vld + i < dump_log.size(); i++)
      if (dump_log[b_vld + i] !== rep[i]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL tmo_data: %0d bad bytes, want 0", bad);
    end
    tests++;
    if (done_cyc != last_rdy_cyc + TMO + 2 || done_busy !== 1'b0) begin
      fails++;
      $display("FAIL tmo_timing: done at %0d busy=%b, want %0d busy=0", done_cyc, done_busy, last_rdy_cyc + TMO + 2);
    end
  endtask

  task automatic test_reset_mid_dump();
    int   k;
    logic ended;
    rep.delete();
    for (int i = 0; i < 10; i++) rep.push_back(8'($urandom));
    @(negedge clk);
    snap();
    per_send  = 1000;
    master_en = 1'b1;
    op_id++;
    op = 2'b10; cmd = 16'h8102; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 2'b00; cmd = 16'h0000;
    k = 0;
    while (n_vld - b_vld < 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (n_vld - b_vld < 5) begin
      fails++;
      $display("FAIL rst_mid_reach: got %0d bytes before limit, want 5", n_vld - b_vld);
    end
    RST_n = 1'b0;
    master_en = 1'b0;
    #1;
    tests++;
    if ({busy, done, dump_vld, dump_cnt, send_cmd, clr_resp_rdy, host_cmd, last_resp} !== '0) begin
      fails++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b vld=%b cnt=%0d send=%b clr=%b hcmd=%h last=%h, want all 0",
               busy, done, dump_vld, dump_cnt, send_cmd, clr_resp_rdy, host_cmd, last_resp);
    end
    repeat (3) @(negedge clk);
    RST_n = 1'b1;
    k = 0;
    while (master_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    tests++;
    if (n_done != b_done || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_no_done: dones=%0d busy=%b, want 0 0", n_done - b_done, busy);
    end
    rep.delete();
    rep.push_back(ACKB);
    run_op(2'b00, 16'h3C3C, 8'h00, 1, 200, ended);
    tests++;
    if (!ended || done_err !== 2'b00 || host_cmd !== 16'h3C3C || last_resp !== ACKB) begin
      fails++;
      $display("FAIL rst_mid_recover: ended=%b err=%b hcmd=%h last=%h, want 1 00 3c3c a5",
               ended, done_err, host_cmd, last_resp);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_ack();
    test_reserved_op();
    test_poll();
    test_start_ignored();
    test_dump();
    test_dump_timeout();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
